// File: rtl/lsu_axil.sv
// lsu_axil: single-outstanding RV32 load/store unit with an AXI4-Lite master port
// Requests from execute (req_*) are checked and then issued as one AXI-Lite read or write.
// The result goes back to writeback on resp_*: loads are aligned and extended, stores return 0.
// Bus side: m_ar*/m_r* carry reads; m_aw*/m_w*/m_b* carry writes.
// Bus addresses are word aligned; m_wstrb selects the byte lanes.
// Optional: define LSU_TRACE_EN to print one mtrace line per response handshake.
module lsu_axil #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RESP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_f3;
  logic [1:0] r_lane;
  logic w_acc, w_err;
  logic [ADDR_W-1:0] w_baddr;
  logic [DATA_W-1:0] w_shift, w_ext, w_wdata;
  logic [3:0] w_wstrb;
  // loads reject 011/11x; stores accept only 000/001/010
  always_comb begin
    w_err = (req_wen ? (req_funct3[2] | &req_funct3[1:0]) : (&req_funct3[1:0] | &req_funct3[2:1]))
          | (req_funct3[1:0] == 2'b01 & req_addr[0])
          | (req_funct3[1:0] == 2'b10 & |req_addr[1:0]);
    w_baddr = {req_addr[ADDR_W-1:2], 2'b00};
    w_wdata = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
              req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    w_wstrb = req_funct3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
              req_funct3[1:0] == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    // funct3[2] marks the unsigned variants, which suppress sign fill
    w_shift = m_rdata >> {r_lane, 3'b000};
    w_ext   = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_shift[7]}}, w_shift[7:0]} :
              r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_shift[15]}}, w_shift[15:0]} : w_shift;
  end
  always_comb begin
    w_next     = r_state;
    w_acc      = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    m_rready   = 1'b0;
    m_bready   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        w_acc     = req_valid;
        if (req_valid) w_next = w_err ? RESP : req_wen ? WR : RD_A;
      end
      RD_A: if (m_arready) w_next = RD_D;
      RD_D: begin
        m_rready = 1'b1;
        if (m_rvalid) w_next = RESP;
      end
      // each channel is done once its valid has dropped or it handshakes now
      WR: if ((~m_awvalid | m_awready) & (~m_wvalid | m_wready)) w_next = WR_B;
      WR_B: begin
        m_bready = 1'b1;
        if (m_bvalid) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_f3       <= '0;
      r_lane     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_awvalid  <= 1'b0;
      m_awaddr   <= '0;
      m_wvalid   <= 1'b0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_f3   <= req_funct3;
        r_lane <= req_addr[1:0];
        if (w_err) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else if (req_wen) begin
          m_awvalid <= 1'b1;
          m_wvalid  <= 1'b1;
          m_awaddr  <= w_baddr;
          m_wdata   <= w_wdata;
          m_wstrb   <= w_wstrb;
        end else begin
          m_arvalid <= 1'b1;
          m_araddr  <= w_baddr;
        end
      end
      if (m_arvalid & m_arready) m_arvalid <= 1'b0;
      if (m_awvalid & m_awready) m_awvalid <= 1'b0;
      if (m_wvalid & m_wready) m_wvalid <= 1'b0;
      if (m_rvalid & m_rready) begin
        resp_err   <= |m_rresp;
        resp_rdata <= |m_rresp ? '0 : w_ext;
      end
      if (m_bvalid & m_bready) begin
        resp_err   <= |m_bresp;
        resp_rdata <= '0;
      end
    end
  end
`ifdef LSU_TRACE_EN
  logic r_wen;
  logic [ADDR_W-1:0] r_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_addr <= '0;
    end else begin
      if (w_acc) begin
        r_wen  <= req_wen;
        r_addr <= req_addr;
      end
      if (resp_valid & resp_ready)
        $display("mtrace: %s addr=%08x data=%08x strb=%b err=%b", r_wen ? "W" : "R", r_addr,
                 r_wen ? m_wdata : resp_rdata, r_wen ? m_wstrb : 4'b0000, resp_err);
    end
  end
`endif
endmodule

// File: tb/tb_lsu_axil.sv
// tb_lsu_axil: directed self-checking bench for lsu_axil with a scoreboard of expected responses
module tb_lsu_axil;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [2:0] req_funct3;
  logic m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [1:0] m_rresp, m_bresp;
  logic [3:0] m_wstrb;
  typedef struct packed {logic [31:0] d; logic e;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  lsu_axil dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    @(negedge clk);
    req_valid = 0;
  endtask
  task automatic get_resp(input int hold);
    logic [31:0] d0;
    logic e0;
    exp_t e;
    int w;
    w = 0;
    while (resp_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("resp_valid_wait", resp_valid, 1);
    d0 = resp_rdata; e0 = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_data", resp_rdata, d0);
      chk("hold_err", resp_err, e0);
      chk("hold_req_ready", req_ready, 0);
    end
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("resp_rdata", resp_rdata, e.d);
      chk("resp_err", resp_err, e.e);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("resp_valid_drop", resp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                         input logic [1:0] rr, input logic [31:0] expd, input logic expe, input int hold);
    m_arready = 1;
    sb.push_back(exp_t'{expd, expe});
    send(0, addr, 32'h0, f3);
    chk("arvalid", m_arvalid, 1);
    chk("araddr", m_araddr, {addr[31:2], 2'b00});
    chk("rready_early", m_rready, 0);
    m_rvalid = 1; m_rdata = word; m_rresp = rr;
    @(negedge clk);
    m_arready = 0;
    chk("arvalid_drop", m_arvalid, 0);
    chk("rready", m_rready, 1);
    chk("resp_valid_early", resp_valid, 0);
    @(negedge clk);
    m_rvalid = 0;
    chk("rready_drop", m_rready, 0);
    chk("resp_valid_t3", resp_valid, 1);
    get_resp(hold);
  endtask
  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd, input int awd,
                          input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es, input logic [1:0] br);
    m_wready = 1;
    m_awready = (awd == 0);
    sb.push_back(exp_t'{32'h0, br != 2'b00});
    send(1, addr, wd, f3);
    chk("awvalid", m_awvalid, 1);
    chk("wvalid", m_wvalid, 1);
    chk("awaddr", m_awaddr, ea);
    chk("wdata", m_wdata, ed);
    chk("wstrb", m_wstrb, es);
    chk("bready_early", m_bready, 0);
    for (int i = 0; i < awd; i++) begin
      @(negedge clk);
      chk("aw_hold", m_awvalid, 1);
      chk("w_drop", m_wvalid, 0);
      chk("bready_wait", m_bready, 0);
      if (i == awd - 1) m_awready = 1;
    end
    @(negedge clk);
    m_awready = 0; m_wready = 0;
    chk("aw_drop", m_awvalid, 0);
    chk("bready", m_bready, 1);
    m_bvalid = 1; m_bresp = br;
    @(negedge clk);
    m_bvalid = 0;
    chk("bready_drop", m_bready, 0);
    get_resp(0);
  endtask
  task automatic do_err(input logic wen, input logic [31:0] addr, input logic [2:0] f3);
    sb.push_back(exp_t'{32'h0, 1'b1});
    send(wen, addr, 32'hDEAD_BEEF, f3);
    chk("err_resp_valid", resp_valid, 1);
    chk("err_arvalid", m_arvalid, 0);
    chk("err_awvalid", m_awvalid, 0);
    chk("err_wvalid", m_wvalid, 0);
    get_resp(0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0; resp_ready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_awaddr", m_awaddr, 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_wstrb", m_wstrb, 0);
    rst = 0;
    @(negedge clk);
    do_load(32'h8000_0100, 3'b000, 32'h8765_43F1, 2'b00, 32'hFFFF_FFF1, 0, 0);
    do_load(32'h8000_0102, 3'b101, 32'h8765_43F1, 2'b00, 32'h0000_8765, 0, 0);
    do_load(32'h8000_0102, 3'b001, 32'h8765_43F1, 2'b00, 32'hFFFF_8765, 0, 0);
    do_load(32'h8000_0101, 3'b100, 32'h8765_43F1, 2'b00, 32'h0000_0043, 0, 0);
    do_load(32'h8000_0103, 3'b000, 32'h8765_43F1, 2'b00, 32'hFFFF_FF87, 0, 0);
    do_load(32'h8000_0100, 3'b010, 32'h8765_43F1, 2'b00, 32'h8765_43F1, 0, 0);
    do_store(32'h8000_0103, 3'b000, 32'h0000_00AB, 3, 32'h8000_0100, 32'hABAB_ABAB, 4'b1000, 2'b00);
    do_store(32'h8000_0102, 3'b001, 32'h1234_ABCD, 0, 32'h8000_0100, 32'hABCD_ABCD, 4'b1100, 2'b00);
    do_store(32'h8000_0104, 3'b010, 32'h1357_9BDF, 1, 32'h8000_0104, 32'h1357_9BDF, 4'b1111, 2'b10);
    do_err(0, 32'h8000_0102, 3'b010);
    do_err(0, 32'h8000_0100, 3'b011);
    do_err(1, 32'h8000_0100, 3'b100);
    do_err(0, 32'h8000_0101, 3'b001);
    do_load(32'h8000_0100, 3'b010, 32'h8765_43F1, 2'b10, 32'h0, 1, 4);
    m_arready = 1;
    send(0, 32'h8000_0100, 32'h0, 3'b010);
    chk("rst_mid_arvalid", m_arvalid, 1);
    @(negedge clk);
    m_arready = 0;
    chk("rst_mid_rready", m_rready, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("post_rst_rready", m_rready, 0);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_arvalid", m_arvalid, 0);
    do_load(32'h8000_0100, 3'b010, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 0, 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
